// File: rtl/cpu_trap_unit_if.sv
// CSR access channel between the core (master) and the trap unit (slave).
// One request per cycle; the slave answers with a single-cycle ack carrying the pre-write value.
interface cpu_trap_unit_if;
  logic        csr_req_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_ack_o;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;

  modport master (
    output csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_ack_o, csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_ack_o, csr_rdata_o, csr_illegal_o
  );
endinterface

// File: rtl/cpu_trap_unit.sv
// Machine-mode CSR file and trap controller: exceptions, mret stacking, direct/vectored mtvec,
// and prioritised timer/external/local interrupts with an input synchroniser.
module cpu_trap_unit #(
  parameter logic [31:0] TRAP_PC       = 32'h0000_0000,
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cpu_trap_unit_if.slave       csr,
  input  logic                 boundary_i,
  input  logic [31:0]          pc_i,
  input  logic                 exc_req_i,
  input  logic [4:0]           exc_cause_i,
  input  logic                 mret_i,
  input  logic                 timer_irq_i,
  input  logic                 ext_irq_i,
  input  logic [((NUM_LOCAL_IRQ == 0) ? 1 : NUM_LOCAL_IRQ)-1:0] local_irq_i,
  output logic                 trap_take_o,
  output logic [31:0]          trap_pc_o,
  output logic [31:0]          mret_pc_o,
  output logic                 irq_pending_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;

  localparam logic [31:0] IRQ_MASK =
    32'h0000_0880 | (32'((64'h1 << NUM_LOCAL_IRQ) - 64'h1) << 16);

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic [31:0] w_irq_raw;
  logic [31:0] w_irq_sync;
  logic [31:0] w_mip;
  logic [31:0] w_pending;
  logic [4:0]  w_irq_code;
  logic [31:0] w_mstatus;
  logic [31:0] w_csr_old;
  logic        w_csr_legal;
  logic [31:0] w_csr_new;
  logic        w_csr_wr;
  logic        w_exc_take;
  logic        w_irq_take;
  logic [31:0] w_trap_cause;
  logic [31:0] w_tvec_base;

  // Gather the implemented interrupt lines into their mip bit positions.
  always_comb begin
    w_irq_raw     = '0;
    w_irq_raw[7]  = timer_irq_i;
    w_irq_raw[11] = ext_irq_i;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
      w_irq_raw[16+i] = local_irq_i[i];
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_irq_sync = w_irq_raw;
    end else begin : g_sync
      logic [31:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= w_irq_raw;
          for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_irq_sync = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_mip     = w_irq_sync & IRQ_MASK;
  assign w_pending = w_mip & r_mie;

  // Bit order already encodes priority: local(16+i) > MEI(11) > MTI(7), so pick the highest set bit.
  always_comb begin
    w_irq_code = '0;
    for (int b = 0; b < 32; b++) begin
      if (w_pending[b]) w_irq_code = 5'(b);
    end
  end

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

  always_comb begin
    w_csr_legal = 1'b1;
    w_csr_old   = '0;
    case (csr.csr_addr_i)
      A_MSTATUS:  w_csr_old = w_mstatus;
      A_MIE:      w_csr_old = r_mie;
      A_MTVEC:    w_csr_old = r_mtvec;
      A_MSCRATCH: w_csr_old = r_mscratch;
      A_MEPC:     w_csr_old = r_mepc;
      A_MCAUSE:   w_csr_old = r_mcause;
      A_MIP:      w_csr_old = w_mip;
      default:    w_csr_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_csr_new = w_csr_old;
    case (csr.csr_op_i)
      2'b01:   w_csr_new = csr.csr_wdata_i;
      2'b10:   w_csr_new = w_csr_old | csr.csr_wdata_i;
      2'b11:   w_csr_new = w_csr_old & ~csr.csr_wdata_i;
      default: w_csr_new = w_csr_old;
    endcase
  end

  assign w_csr_wr = csr.csr_req_i & w_csr_legal & (csr.csr_op_i != 2'b00);

  // An mret at the check point suppresses both exceptions and interrupts.
  assign w_exc_take   = boundary_i & ~mret_i & exc_req_i;
  assign w_irq_take   = boundary_i & ~mret_i & ~exc_req_i & r_mstatus_mie & (|w_pending);
  assign trap_take_o  = w_exc_take | w_irq_take;
  assign w_trap_cause = exc_req_i ? {27'b0, exc_cause_i} : {1'b1, 26'b0, w_irq_code};

  assign w_tvec_base = {r_mtvec[31:2], 2'b00};
  assign trap_pc_o   = ((r_mtvec[1:0] == 2'b01) && !exc_req_i)
                     ? w_tvec_base + {25'b0, w_irq_code, 2'b00}
                     : w_tvec_base;

  assign mret_pc_o     = r_mepc;
  assign irq_pending_o = |w_pending;

  assign csr.csr_ack_o     = r_ack;
  assign csr.csr_rdata_o   = r_rdata;
  assign csr.csr_illegal_o = r_illegal;

  // CSR state; trap/mret updates are placed last so they override a same-edge CSR write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= TRAP_PC;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_ack          <= 1'b0;
      r_rdata        <= '0;
      r_illegal      <= 1'b0;
    end else begin
      r_ack <= csr.csr_req_i;
      if (csr.csr_req_i) begin
        r_rdata   <= w_csr_legal ? w_csr_old : 32'h0;
        r_illegal <= ~w_csr_legal;
      end
      if (w_csr_wr) begin
        case (csr.csr_addr_i)
          A_MSTATUS: begin
            r_mstatus_mie  <= w_csr_new[3];
            r_mstatus_mpie <= w_csr_new[7];
          end
          A_MIE:      r_mie      <= w_csr_new & IRQ_MASK;
          A_MTVEC:    r_mtvec    <= w_csr_new;
          A_MSCRATCH: r_mscratch <= w_csr_new;
          A_MEPC:     r_mepc     <= w_csr_new & 32'hFFFF_FFFC;
          A_MCAUSE:   r_mcause   <= w_csr_new;
          default: ;
        endcase
      end
      if (trap_take_o) begin
        r_mepc         <= pc_i & 32'hFFFF_FFFC;
        r_mcause       <= w_trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (mret_i) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Self-checking bench for cpu_trap_unit: CSR vector table through a scoreboard queue,
// plus hand-written interrupt, exception, mret and reset sequences.
module tb_cpu_trap_unit;

  localparam logic [31:0] TB_TRAP_PC = 32'h0000_0200;

  logic        clk;
  logic        rst_n;
  logic        boundary;
  logic [31:0] pc;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic        mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [3:0]  local_irq;
  logic        trap_take;
  logic [31:0] trap_pc;
  logic [31:0] mret_pc;
  logic        irq_pending;

  cpu_trap_unit_if bus ();

  cpu_trap_unit #(
    .TRAP_PC       (TB_TRAP_PC),
    .NUM_LOCAL_IRQ (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .csr           (bus),
    .boundary_i    (boundary),
    .pc_i          (pc),
    .exc_req_i     (exc_req),
    .exc_cause_i   (exc_cause),
    .mret_i        (mret),
    .timer_irq_i   (timer_irq),
    .ext_irq_i     (ext_irq),
    .local_irq_i   (local_irq),
    .trap_take_o   (trap_take),
    .trap_pc_o     (trap_pc),
    .mret_pc_o     (mret_pc),
    .irq_pending_o (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire any CSR ack against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.csr_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack: got ack=1 expected ack=0");
      end else begin
        e = sb.pop_front();
        chk($sformatf("rdata_%03h", e.addr), bus.csr_rdata_o, e.rdata);
        chk($sformatf("illegal_%03h", e.addr), 32'(bus.csr_illegal_o), 32'(e.ill));
      end
    end else if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_ack: got ack=%b expected ack=1", bus.csr_ack_o);
      sb.delete();
    end
  endtask

  task automatic csr_acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic ill);
    exp_t e;
    bus.csr_req_i   = 1'b1;
    bus.csr_op_i    = op;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = wdata;
    e.addr  = addr;
    e.rdata = rdata;
    e.ill   = ill;
    sb.push_back(e);
    tick();
    bus.csr_req_i = 1'b0;
  endtask

  task automatic add(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic ill);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ill = ill;
    vt.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    boundary = 1'b0; pc = '0; exc_req = 1'b0; exc_cause = '0; mret = 1'b0;
    timer_irq = 1'b0; ext_irq = 1'b0; local_irq = '0;
    bus.csr_req_i = 1'b0; bus.csr_op_i = '0; bus.csr_addr_i = '0; bus.csr_wdata_i = '0;

    add(2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0);
    add(2'd0, 12'h304, 32'h0,         32'h0,         1'b0);
    add(2'd0, 12'h305, 32'h0,         TB_TRAP_PC,    1'b0);
    add(2'd0, 12'h340, 32'h0,         32'h0,         1'b0);
    add(2'd0, 12'h341, 32'h0,         32'h0,         1'b0);
    add(2'd0, 12'h342, 32'h0,         32'h0,         1'b0);
    add(2'd0, 12'h344, 32'h0,         32'h0,         1'b0);
    add(2'd0, 12'h7C0, 32'h0,         32'h0,         1'b1);
    add(2'd1, 12'h7C0, 32'hFFFF_FFFF, 32'h0,         1'b1);
    add(2'd1, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0);
    add(2'd2, 12'h340, 32'h0000_0F00, 32'hDEAD_BEEF, 1'b0);
    add(2'd3, 12'h340, 32'hFF00_0000, 32'hDEAD_BFEF, 1'b0);
    add(2'd0, 12'h340, 32'h0,         32'h00AD_BFEF, 1'b0);
    add(2'd1, 12'h341, 32'h1234_5677, 32'h0,         1'b0);
    add(2'd0, 12'h341, 32'h0,         32'h1234_5674, 1'b0);
    add(2'd1, 12'h344, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(2'd0, 12'h344, 32'h0,         32'h0,         1'b0);
    add(2'd1, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0);
    add(2'd1, 12'h304, 32'h0,         32'h000F_0880, 1'b0);
    add(2'd1, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0);
    add(2'd1, 12'h300, 32'h0,         32'h0000_1888, 1'b0);
    add(2'd0, 12'h300, 32'h0,         32'h0000_1800, 1'b0);
    add(2'd1, 12'h342, 32'h8000_000B, 32'h0,         1'b0);
    add(2'd0, 12'h342, 32'h0,         32'h8000_000B, 1'b0);

    repeat (3) tick();
    chk("rst_ack",       32'(bus.csr_ack_o), 32'h0);
    chk("rst_rdata",     bus.csr_rdata_o,    32'h0);
    chk("rst_illegal",   32'(bus.csr_illegal_o), 32'h0);
    chk("rst_trap_take", 32'(trap_take),     32'h0);
    chk("rst_mret_pc",   mret_pc,            32'h0);
    rst_n = 1'b1;
    tick();

    // Back-to-back CSR table.
    foreach (vt[i]) csr_acc(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].ill);
    tick();

    // Timer interrupt through the two-stage synchroniser.
    csr_acc(2'd1, 12'h304, 32'h80, 32'h0, 1'b0);
    csr_acc(2'd2, 12'h300, 32'h8,  32'h1800, 1'b0);
    timer_irq = 1'b1; boundary = 1'b1; pc = 32'h104;
    #1;
    chk("tmr_take_c0",    32'(trap_take),   32'h0);
    chk("tmr_pending_c0", 32'(irq_pending), 32'h0);
    tick();
    chk("tmr_take_c1",    32'(trap_take),   32'h0);
    tick();
    chk("tmr_take_c2",    32'(trap_take),   32'h1);
    chk("tmr_trap_pc",    trap_pc,          TB_TRAP_PC);
    chk("tmr_pending_c2", 32'(irq_pending), 32'h1);
    tick();
    boundary = 1'b0; pc = '0;
    csr_acc(2'd0, 12'h341, 32'h0, 32'h104,       1'b0);
    csr_acc(2'd0, 12'h342, 32'h0, 32'h8000_0007, 1'b0);
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1880,      1'b0);
    boundary = 1'b1;
    #1;
    chk("mie0_no_take",  32'(trap_take),   32'h0);
    chk("mie0_pending",  32'(irq_pending), 32'h1);
    chk("mret_pc",       mret_pc,          32'h104);
    mret = 1'b1;
    #1;
    chk("mret_no_take0", 32'(trap_take), 32'h0);
    tick();
    mret = 1'b0; boundary = 1'b0;
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1888, 1'b0);
    mret = 1'b1; boundary = 1'b1;
    #1;
    chk("mret_no_take1", 32'(trap_take), 32'h0);
    tick();
    mret = 1'b0; boundary = 1'b0;
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1888, 1'b0);

    // Vectored mode and interrupt priority.
    csr_acc(2'd1, 12'h305, 32'h1001,    TB_TRAP_PC, 1'b0);
    csr_acc(2'd1, 12'h304, 32'h3_0880,  32'h80,     1'b0);
    local_irq = 4'b0010; ext_irq = 1'b1;
    tick(); tick();
    chk("vec_pending",  32'(irq_pending), 32'h1);
    chk("vec_no_bound", 32'(trap_take),   32'h0);
    boundary = 1'b1; pc = 32'h208;
    #1;
    chk("vec_take_l1",  32'(trap_take), 32'h1);
    chk("vec_pc_l1",    trap_pc,        32'h1044);
    tick();
    boundary = 1'b0;
    csr_acc(2'd0, 12'h342, 32'h0, 32'h8000_0011, 1'b0);
    csr_acc(2'd0, 12'h341, 32'h0, 32'h208,       1'b0);
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1880,      1'b0);
    local_irq = '0;
    tick(); tick();
    csr_acc(2'd2, 12'h300, 32'h8, 32'h1880, 1'b0);
    boundary = 1'b1; pc = 32'h20C;
    #1;
    chk("vec_take_mei", 32'(trap_take), 32'h1);
    chk("vec_pc_mei",   trap_pc,        32'h102C);
    tick();
    boundary = 1'b0;
    csr_acc(2'd0, 12'h342, 32'h0, 32'h8000_000B, 1'b0);
    ext_irq = 1'b0;
    tick(); tick();
    csr_acc(2'd2, 12'h300, 32'h8, 32'h1880, 1'b0);
    boundary = 1'b1;
    #1;
    chk("vec_take_mti", 32'(trap_take), 32'h1);
    chk("vec_pc_mti",   trap_pc,        32'h101C);
    tick();
    boundary = 1'b0;
    csr_acc(2'd0, 12'h342, 32'h0, 32'h8000_0007, 1'b0);

    // Exception with MIE=0 and a pending timer uses the base address.
    exc_req = 1'b1; exc_cause = 5'd2; boundary = 1'b1; pc = 32'h300;
    #1;
    chk("exc_take", 32'(trap_take), 32'h1);
    chk("exc_pc",   trap_pc,        32'h1000);
    tick();
    exc_req = 1'b0; boundary = 1'b0;
    csr_acc(2'd0, 12'h342, 32'h0, 32'h2,    1'b0);
    csr_acc(2'd0, 12'h341, 32'h0, 32'h300,  1'b0);
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1800, 1'b0);

    // csrrs mstatus on the same edge as an exception: trap update wins.
    exc_req = 1'b1; exc_cause = 5'd5; boundary = 1'b1; pc = 32'h407;
    #1;
    chk("exc_csr_take", 32'(trap_take), 32'h1);
    csr_acc(2'd2, 12'h300, 32'h8, 32'h1800, 1'b0);
    exc_req = 1'b0; boundary = 1'b0;
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1800, 1'b0);
    csr_acc(2'd0, 12'h342, 32'h0, 32'h5,    1'b0);
    csr_acc(2'd0, 12'h341, 32'h0, 32'h404,  1'b0);

    // Exception beats an enabled pending interrupt.
    csr_acc(2'd2, 12'h300, 32'h8, 32'h1800, 1'b0);
    exc_req = 1'b1; exc_cause = 5'd11; boundary = 1'b1; pc = 32'h500;
    #1;
    chk("exc_prio_take", 32'(trap_take), 32'h1);
    chk("exc_prio_pc",   trap_pc,        32'h1000);
    tick();
    exc_req = 1'b0; boundary = 1'b0;
    csr_acc(2'd0, 12'h342, 32'h0, 32'hB,    1'b0);
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1880, 1'b0);

    // Reset in the middle of a CSR write.
    timer_irq = 1'b0;
    tick(); tick(); tick();
    chk("irq_cleared", 32'(irq_pending), 32'h0);
    bus.csr_req_i = 1'b1; bus.csr_op_i = 2'd1; bus.csr_addr_i = 12'h340; bus.csr_wdata_i = 32'h55;
    rst_n = 1'b0;
    tick();
    chk("rst_mid_ack", 32'(bus.csr_ack_o), 32'h0);
    bus.csr_req_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    csr_acc(2'd0, 12'h340, 32'h0, 32'h0,        1'b0);
    csr_acc(2'd0, 12'h305, 32'h0, TB_TRAP_PC,   1'b0);
    csr_acc(2'd0, 12'h300, 32'h0, 32'h1800,     1'b0);
    csr_acc(2'd0, 12'h341, 32'h0, 32'h0,        1'b0);
    tick();
    chk("sb_drain", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
